// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 mode encodings,
// exception-cause encodings and the control FSM state type.
package load_store_unit_pkg;

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_ACCESS   = 2'b10,
    CAUSE_ILLEGAL  = 2'b11
  } exc_cause_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_align_chk.sv
// Combinational request checker: flags illegal modes, misaligned halfword/word
// addresses and addresses beyond the data memory, in that priority order.
module lsu_align_chk
  import load_store_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DM_AW = 10
) (
  input  logic            we,
  input  logic [2:0]      mode,
  input  logic [XLEN-1:0] addr,
  output logic            pass,
  output logic [1:0]      cause
);

  logic illegal;
  logic misaligned;
  logic out_of_range;

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (mode)
      MODE_B:  misaligned = 1'b0;
      MODE_H:  misaligned = addr[0];
      MODE_W:  misaligned = (addr[1:0] != 2'b00);
      // Unsigned variants only make sense for loads
      MODE_BU: illegal = we;
      MODE_HU: begin
        illegal    = we;
        misaligned = addr[0];
      end
      default: illegal = 1'b1;
    endcase

    out_of_range = (addr[XLEN-1:DM_AW] != '0);

    pass  = 1'b0;
    cause = CAUSE_NONE;
    if (illegal) begin
      cause = CAUSE_ILLEGAL;
    end else if (misaligned) begin
      cause = CAUSE_MISALIGN;
    end else if (out_of_range) begin
      cause = CAUSE_ACCESS;
    end else begin
      pass = 1'b1;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between EX and a registered-read data memory: one op in
// flight, loads returned through a WB valid/ready handshake, faults reported.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DM_AW = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_mode,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  input  logic [4:0]       req_rd,
  input  logic             flush,
  output logic             dm_we,
  output logic             dm_re,
  output logic [2:0]       dm_mode,
  output logic [DM_AW-1:0] dm_addr,
  output logic [XLEN-1:0]  dm_wdata,
  input  logic [XLEN-1:0]  dm_rdata,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             exc_valid,
  output logic [1:0]       exc_cause,
  output logic [XLEN-1:0]  exc_addr
);

  lsu_state_e state, state_next;

  logic             op_we;
  logic [2:0]       op_mode;
  logic [DM_AW-1:0] op_addr;
  logic [XLEN-1:0]  op_wdata;
  logic [4:0]       op_rd;

  logic       chk_pass;
  logic [1:0] chk_cause;
  logic       accept;
  logic       reject;
  logic       capture;

  lsu_align_chk #(.XLEN(XLEN), .DM_AW(DM_AW)) u_align_chk (
    .we    (req_we),
    .mode  (req_mode),
    .addr  (req_addr),
    .pass  (chk_pass),
    .cause (chk_cause)
  );

  assign accept = (state == S_IDLE) && req_valid && chk_pass;
  assign reject = (state == S_IDLE) && req_valid && !chk_pass;
  assign wb_rd  = op_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    dm_we      = 1'b0;
    dm_re      = 1'b0;
    dm_mode    = '0;
    dm_addr    = '0;
    dm_wdata   = '0;
    wb_valid   = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (accept) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        dm_we      = op_we;
        dm_re      = ~op_we;
        dm_mode    = op_mode;
        dm_addr    = op_addr;
        dm_wdata   = op_wdata;
        state_next = op_we ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (flush) begin
          state_next = S_IDLE;
        end else begin
          capture    = 1'b1;
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        // Flush drops the result combinationally so WB never sees it
        if (flush) begin
          state_next = S_IDLE;
        end else begin
          wb_valid = 1'b1;
          if (wb_ready) state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_we    <= 1'b0;
      op_mode  <= '0;
      op_addr  <= '0;
      op_wdata <= '0;
      op_rd    <= '0;
    end else if (accept) begin
      op_we    <= req_we;
      op_mode  <= req_mode;
      op_addr  <= req_addr[DM_AW-1:0];
      op_wdata <= req_wdata;
      op_rd    <= req_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       wb_data <= '0;
    else if (capture) wb_data <= dm_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_valid <= 1'b0;
      exc_cause <= '0;
      exc_addr  <= '0;
    end else begin
      exc_valid <= reject;
      if (reject) begin
        exc_cause <= chk_cause;
        exc_addr  <= req_addr;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected memory
// ops, WB transfers and exceptions; a negedge monitor pops and compares them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        flush;
  logic        dm_we;
  logic        dm_re;
  logic [2:0]  dm_mode;
  logic [9:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [31:0] exc_addr;

  int checks   = 0;
  int failures = 0;

  logic [63:0] dm_q[$];
  logic [63:0] wb_q[$];
  logic [63:0] exc_q[$];

  // Word-granular memory model: returns the whole stored word whatever the mode
  logic [31:0] mem [0:255];

  load_store_unit #(.XLEN(32), .DM_AW(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_mode  (req_mode),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_rd    (req_rd),
    .flush     (flush),
    .dm_we     (dm_we),
    .dm_re     (dm_re),
    .dm_mode   (dm_mode),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .exc_valid (exc_valid),
    .exc_cause (exc_cause),
    .exc_addr  (exc_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dm_we) mem[dm_addr[9:2]] <= dm_wdata;
    if (dm_re) dm_rdata <= mem[dm_addr[9:2]];
  end

  function automatic void checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  function automatic void failNow(string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=event required=none", name);
  endfunction

  function automatic logic [63:0] dmExp(logic we, logic [2:0] mode, logic [31:0] addr,
                                        logic [31:0] wdata);
    return {17'b0, we, ~we, mode, addr[9:0], (we ? wdata : 32'h0)};
  endfunction

  // Monitor: every DUT output event must match the head of its queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (dm_we && dm_re) failNow("dm_both_strobes");
      if (dm_we || dm_re) begin
        if (dm_q.size() == 0) failNow("dm_unexpected");
        else checkOutput("dm_op", {17'b0, dm_we, dm_re, dm_mode, dm_addr, dm_wdata},
                         dm_q.pop_front());
      end
      if (wb_valid && wb_ready) begin
        if (wb_q.size() == 0) failNow("wb_unexpected");
        else checkOutput("wb_xfer", {27'b0, wb_rd, wb_data}, wb_q.pop_front());
      end
      if (exc_valid) begin
        if (exc_q.size() == 0) failNow("exc_unexpected");
        else checkOutput("exc", {30'b0, exc_cause, exc_addr}, exc_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(string tag);
    checkOutput({tag, "_ctl"},
                {47'b0, req_ready, dm_we, dm_re, dm_mode, wb_valid, wb_rd, exc_valid, exc_cause},
                {47'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 5'd0, 1'b0, 2'b00});
    checkOutput({tag, "_dm_addr"}, {54'b0, dm_addr}, 64'h0);
    checkOutput({tag, "_data"}, {dm_wdata, wb_data}, 64'h0);
    checkOutput({tag, "_exc_addr"}, {32'b0, exc_addr}, 64'h0);
  endtask

  // Issues one request (returns #1 after the accept edge); cause!=0 means a fault is expected
  task automatic applyStimulus(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [4:0] rd,
                               input logic [1:0] cause, input logic expect_wb,
                               input logic [31:0] wb_exp);
    int n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) failNow("req_ready_timeout");
    if (cause != 2'b00) begin
      exc_q.push_back({30'b0, cause, addr});
    end else begin
      dm_q.push_back(dmExp(we, mode, addr, wdata));
      if (!we && expect_wb) wb_q.push_back({27'b0, rd, wb_exp});
    end
    req_we    = we;
    req_mode  = mode;
    req_addr  = addr;
    req_wdata = wdata;
    req_rd    = rd;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic applyFault(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                            input logic [1:0] cause, string name);
    applyStimulus(we, mode, addr, 32'hA5A5_A5A5, 5'd1, cause, 1'b0, 32'h0);
    checkOutput({name, "_stay_idle"}, {62'b0, req_ready, dm_re}, {62'b0, 1'b1, 1'b0});
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_mode  = 3'b000;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_rd    = 5'd0;
    flush     = 1'b0;
    wb_ready  = 1'b1;
    dm_rdata  = 32'h0;

    tick();
    tick();
    checkResetValues("reset");
    rst_n = 1'b1;
    tick();

    // Store w: strobe in cycle 1, ready back in cycle 2
    applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 5'd0, 2'b00, 1'b0, 32'h0);
    checkOutput("st_c1", {62'b0, req_ready, dm_we}, {62'b0, 1'b0, 1'b1});
    tick();
    checkOutput("st_c2", {62'b0, req_ready, dm_we}, {62'b0, 1'b1, 1'b0});

    // Load w: wb_valid first high in cycle 3
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 5'd5, 2'b00, 1'b1, 32'hDEAD_BEEF);
    checkOutput("ld_c1_wbv", {63'b0, wb_valid}, 64'h0);
    tick();
    checkOutput("ld_c2_wbv", {63'b0, wb_valid}, 64'h0);
    tick();
    checkOutput("ld_c3", {31'b0, wb_valid, wb_data}, {31'b0, 1'b1, 32'hDEAD_BEEF});
    tick();

    // Top-of-memory boundary: last word and last bytes are legal
    applyStimulus(1'b1, 3'b010, 32'h3FC, 32'h1234_5678, 5'd0, 2'b00, 1'b0, 32'h0);
    applyStimulus(1'b0, 3'b100, 32'h3FC, 32'h0, 5'd7, 2'b00, 1'b1, 32'h1234_5678);
    applyStimulus(1'b0, 3'b101, 32'h3FE, 32'h0, 5'd9, 2'b00, 1'b1, 32'h1234_5678);
    applyStimulus(1'b0, 3'b000, 32'h3FF, 32'h0, 5'd10, 2'b00, 1'b1, 32'h1234_5678);

    // Fault checks including priority between overlapping causes
    applyFault(1'b0, 3'b001, 32'h11, 2'b01, "ld_h_odd");
    tick();
    checkOutput("exc_pulse_end", {63'b0, exc_valid}, 64'h0);
    applyFault(1'b0, 3'b000, 32'h400, 2'b10, "ld_b_oor");
    applyFault(1'b0, 3'b011, 32'h10, 2'b11, "ld_mode011");
    applyFault(1'b1, 3'b100, 32'h10, 2'b11, "st_bu");
    applyFault(1'b1, 3'b101, 32'h10, 2'b11, "st_hu");
    applyFault(1'b0, 3'b111, 32'h10, 2'b11, "ld_mode111");
    applyFault(1'b0, 3'b010, 32'h12, 2'b01, "ld_w_mis");
    applyFault(1'b0, 3'b001, 32'h401, 2'b01, "prio_mis_oor");
    applyFault(1'b0, 3'b011, 32'h401, 2'b11, "prio_ill_mis");
    applyFault(1'b0, 3'b000, 32'h8000_0000, 2'b10, "ld_b_high");
    tick();

    // WB back-pressure: result held stable for 5 cycles
    wb_ready = 1'b0;
    applyStimulus(1'b0, 3'b010, 32'h3FC, 32'h0, 5'd3, 2'b00, 1'b1, 32'h1234_5678);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_hold", {26'b0, wb_valid, wb_rd, wb_data}, {26'b0, 1'b1, 5'd3, 32'h1234_5678});
      tick();
    end
    wb_ready = 1'b1;
    tick();
    tick();

    // Flush in RESP drops the result and returns to IDLE
    wb_ready = 1'b0;
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 5'd4, 2'b00, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("flush_c3_wbv", {63'b0, wb_valid}, 64'h1);
    tick();
    flush = 1'b1;
    #1;
    checkOutput("flush_c4_wbv", {63'b0, wb_valid}, 64'h0);
    tick();
    flush = 1'b0;
    checkOutput("flush_c5", {62'b0, req_ready, wb_valid}, {62'b0, 1'b1, 1'b0});
    wb_ready = 1'b1;

    // Flush during ISSUE must not cancel a store
    applyStimulus(1'b1, 3'b000, 32'h20, 32'h0000_00C3, 5'd0, 2'b00, 1'b0, 32'h0);
    flush = 1'b1;
    #1;
    checkOutput("flush_issue_st", {63'b0, dm_we}, 64'h1);
    tick();
    flush = 1'b0;

    // Reset while a load waits in WAIT
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 5'd6, 2'b00, 1'b0, 32'h0);
    tick();
    rst_n = 1'b0;
    #1;
    checkResetValues("rst_wait");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("post_rst_quiet", {61'b0, wb_valid, dm_we, dm_re}, 64'h0);
      tick();
    end

    checkOutput("dm_q_empty", 64'(dm_q.size()), 64'h0);
    checkOutput("wb_q_empty", 64'(wb_q.size()), 64'h0);
    checkOutput("exc_q_empty", 64'(exc_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failNow("global_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter XLEN, 32, data/address width.
REQ-002 Parameter DM_AW, 10, data-memory byte-address width; legal range 0..2^DM_AW-1.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  EX stage presents a memory op.
REQ-006 req_ready  out  1  unit accepts op this cycle; EX stalls while low.
REQ-007 req_we  in  1  1=store, 0=load.
REQ-008 req_mode  in  3  funct3: b=000 h=001 w=010 bu=100 hu=101.
REQ-009 req_addr  in  XLEN  effective byte address.
REQ-010 req_wdata  in  XLEN  store data.
REQ-011 req_rd  in  5  load destination register.
REQ-012 flush  in  1  squash pending load result.
REQ-013 dm_we, dm_re  out  1 each  data-memory write/read strobes.
REQ-014 dm_mode  out  3  mode to data memory.
REQ-015 dm_addr  out  DM_AW  byte address to data memory.
REQ-016 dm_wdata  out  XLEN  store data to data memory.
REQ-017 dm_rdata  in  XLEN  data-memory registered read data, valid the cycle after dm_re.
REQ-018 wb_valid  out  1  load result available; wb_ready  in  1  WB accepts.
REQ-019 wb_rd  out  5, wb_data  out  XLEN  load destination and value.
REQ-020 exc_valid  out  1 (one-cycle pulse), exc_cause  out  2 (01 misaligned, 10 access fault, 11 illegal mode), exc_addr  out  XLEN.

Function
REQ-021 FSM states IDLE, ISSUE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-022 IDLE, req_valid=1, checks pass: register op fields, go ISSUE next cycle.
REQ-023 Checks in priority order: illegal mode (011,110,111; stores also reject 100,101) -> cause 11; h/hu with addr[0]=1 or w with addr[1:0]!=0 -> cause 01; addr[XLEN-1:DM_AW]!=0 -> cause 10.
REQ-024 Failed check: no memory access, exc_valid=1 next cycle with cause and req_addr, FSM stays IDLE.
REQ-025 ISSUE: drive dm_mode, dm_addr=addr[DM_AW-1:0], dm_wdata for exactly one cycle; dm_we=req_we, dm_re=~req_we.
REQ-026 ISSUE store -> IDLE; store accepted at cycle 0 drives dm_we at cycle 1, req_ready high again at cycle 2.
REQ-027 ISSUE load -> WAIT; WAIT captures dm_rdata into wb_data register, -> RESP.
REQ-028 RESP: wb_valid=1, wb_data/wb_rd held stable until wb_ready=1; transfer -> IDLE.
REQ-029 Load latency: accept cycle 0, wb_valid first high cycle 3.
REQ-030 flush=1 in WAIT or RESP: result dropped, wb_valid low from that cycle on, FSM -> IDLE next cycle; flush in ISSUE does not cancel a store; flush in IDLE ignored.
REQ-031 dm_we/dm_re 0 in every state except ISSUE; never both 1.
REQ-032 Addresses wrap never: out-of-range rejected per REQ-023, not truncated.

Reset
REQ-033 rst_n low: FSM IDLE, req_ready=1, dm_we=dm_re=0, dm_mode=0, dm_addr=0, dm_wdata=0, wb_valid=0, wb_rd=0, wb_data=0, exc_valid=0, exc_cause=0, exc_addr=0.
REQ-034 Reset asserted mid-operation abandons the op; no strobe or wb_valid after deassertion until a new request.

Structure
REQ-035 Shared package: mode encodings, exception-cause encodings, FSM state type.
REQ-036 One sub-module lsu_align_chk: combinational mode/address checker producing pass flag and cause.

Verification
REQ-037 Store w 0xDEADBEEF @0x10 -> cycle 1 dm_we=1 dm_mode=010 dm_addr=0x10; req_ready low cycle 1, high cycle 2.
REQ-038 Load w @0x10, dm_rdata=0xDEADBEEF cycle 2 -> cycle 3 wb_valid=1 wb_data=0xDEADBEEF wb_rd=req_rd.
REQ-039 Load h @0x11 -> exc_valid cause 01 exc_addr 0x11, dm_re never asserted.
REQ-040 Load b @0x400 -> cause 10; mode 011 -> cause 11; store bu -> cause 11.
REQ-041 Load accepted, wb_ready=0 for 5 cycles -> wb_valid/wb_data stable; flush in cycle 4 -> wb_valid low, IDLE next cycle.
REQ-042 rst_n low during WAIT -> all outputs at reset values, no wb_valid after release.
